// File: rtl/strand_deserializer_if.sv
// Handshake bundle between the digit-serial link and the word-level datapath.
// The slave side is the deserializer; the master side drives digits and consumes words.
interface strand_deserializer_if #(
  parameter int N     = 4,
  parameter int CNT_W = 16
);
  logic [1:0]       digit_in;
  logic             digit_valid;
  logic             digit_sof;
  logic             digit_ready;
  logic [2*N-1:0]   word_out;
  logic             word_valid;
  logic             word_ready;
  logic             frame_err;
  logic [CNT_W-1:0] word_count;

  modport master (
    output digit_in, digit_valid, digit_sof, word_ready,
    input  digit_ready, word_out, word_valid, frame_err, word_count
  );

  modport slave (
    input  digit_in, digit_valid, digit_sof, word_ready,
    output digit_ready, word_out, word_valid, frame_err, word_count
  );
endinterface

// File: rtl/strand_deserializer.sv
// Receive end of the strand link: de-complements 2-bit digits and packs N of them
// into a word, with one-deep output buffering and sof-based frame resync.
module strand_deserializer #(
  parameter int N       = 4,
  parameter int REVERSE = 0,
  parameter int CNT_W   = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  strand_deserializer_if.slave link
);

  localparam int              CW   = $clog2(N);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  logic [CW-1:0]    r_cnt;
  logic [2*N-1:0]   r_acc;
  logic [2*N-1:0]   r_word;
  logic             r_word_valid;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_word_count;

  logic             w_ready;
  logic             w_accept;
  logic             w_restart;
  logic             w_complete;
  logic             w_consume;
  logic [1:0]       w_digit;
  logic [CW-1:0]    w_idx;
  logic [CW-1:0]    w_slot;
  logic [2*N-1:0]   w_merged;

  // Only the digit that would complete a word must wait for the output slot to free up.
  assign w_ready    = !((r_cnt == LAST) && r_word_valid && !link.word_ready);
  assign w_accept   = link.digit_valid && w_ready;
  assign w_restart  = w_accept && link.digit_sof && (r_cnt != '0);
  assign w_complete = w_accept && !w_restart && (r_cnt == LAST);
  assign w_consume  = r_word_valid && link.word_ready;
  assign w_digit    = {link.digit_in[1], ~link.digit_in[0]};
  assign w_idx      = w_restart ? '0 : r_cnt;

  generate
    if (REVERSE != 0) begin : g_rev
      assign w_slot = LAST - w_idx;
    end else begin : g_fwd
      assign w_slot = w_idx;
    end
  endgenerate

  always_comb begin
    w_merged = r_acc;
    for (int k = 0; k < N; k++) begin
      if (w_slot == CW'(k)) begin
        w_merged[2*k +: 2] = w_digit;
      end
    end
  end

  // A restarting digit lands in slot 0 of a fresh word; completion takes priority over consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_frame_err <= w_restart;
      if (w_accept) begin
        r_acc <= w_merged;
        if (w_restart) begin
          r_cnt <= CW'(1);
        end else if (w_complete) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_complete) begin
        r_word       <= w_merged;
        r_word_valid <= 1'b1;
        r_word_count <= r_word_count + 1'b1;
      end else if (w_consume) begin
        r_word_valid <= 1'b0;
      end
    end
  end

  assign link.digit_ready = w_ready;
  assign link.word_out    = r_word;
  assign link.word_valid  = r_word_valid;
  assign link.frame_err   = r_frame_err;
  assign link.word_count  = r_word_count;

endmodule
